tile_start_sequencer: RTL and testbench



---
 rtl/tile_start_sequencer.sv | 103 ++++++++++
 tb/tb_tile_start_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/tile_start_sequencer.sv
// Holds every tile in reset, then releases tiles one at a time in index order,
// then forwards processors_en to all tiles. Define SEQ_TIMEOUT_EN for per-tile ready timeout.
module tile_start_sequencer #(
  parameter int TILE_NUM       = 16,
  parameter int RESET_HOLD     = 8,
  parameter int STAGGER_CYCLES = 4,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                processors_en,
  input  logic [TILE_NUM-1:0] tile_ready,
  output logic [TILE_NUM-1:0] tile_reset,
  output logic [TILE_NUM-1:0] tile_en,
  output logic                seq_done,
  output logic [TILE_NUM-1:0] timeout_flags
);

  localparam int HS_MAX  = (RESET_HOLD > STAGGER_CYCLES) ? RESET_HOLD : STAGGER_CYCLES;
  localparam int CNT_MAX = (HS_MAX > TIMEOUT_CYCLES) ? HS_MAX : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int TILE_W  = (TILE_NUM > 1) ? $clog2(TILE_NUM) : 1;

  localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(RESET_HOLD - 1);
  localparam logic [CNT_W-1:0]  STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [TILE_W-1:0] LAST_TILE    = TILE_W'(TILE_NUM - 1);

  typedef enum logic [2:0] {IDLE, HOLD, RELEASE, WAIT_RDY, RUN} state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_sat;
  logic [TILE_W-1:0]  cur_tile;
  logic               ready_now;
  logic               stagger_met;
  logic               advance;

  // Counter sticks at all-ones so a long ready wait cannot wrap and re-arm the stagger.
  assign cnt_sat     = (cnt == '1) ? cnt : cnt + CNT_W'(1);
  assign ready_now   = tile_ready[cur_tile];
  assign stagger_met = (cnt >= STAGGER_LAST);

`ifdef SEQ_TIMEOUT_EN
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic timed_out;
  assign timed_out = !(ready_now && stagger_met) && (cnt >= TIMEOUT_LAST);
  assign advance   = (ready_now && stagger_met) || timed_out;
`else
  assign advance       = ready_now && stagger_met;
  assign timeout_flags = '0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      cur_tile   <= '0;
      tile_reset <= '1;
      tile_en    <= '0;
      seq_done   <= 1'b0;
`ifdef SEQ_TIMEOUT_EN
      timeout_flags <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          cnt   <= '0;
          state <= HOLD;
        end
        HOLD: begin
          cnt <= cnt_sat;
          if (cnt == HOLD_LAST) state <= RELEASE;
        end
        RELEASE: begin
          tile_reset[cur_tile] <= 1'b0;
          cnt                  <= '0;
          state                <= WAIT_RDY;
        end
        WAIT_RDY: begin
          cnt <= cnt_sat;
          if (advance) begin
`ifdef SEQ_TIMEOUT_EN
            if (timed_out) timeout_flags[cur_tile] <= 1'b1;
`endif
            if (cur_tile == LAST_TILE) begin
              state    <= RUN;
              seq_done <= 1'b1;
            end else begin
              cur_tile <= cur_tile + TILE_W'(1);
              state    <= RELEASE;
            end
          end
        end
        RUN: begin
          tile_en <= {TILE_NUM{processors_en}};
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tile_start_sequencer.sv
// Bench for tile_start_sequencer: per-edge comparison against an edge-arithmetic model.
module tb_tile_start_sequencer;

  localparam int N     = 16;
  localparam int H     = 8;
  localparam int S     = 4;
  localparam int T     = 32;
  localparam int NEVER = 1_000_000;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         processors_en = 1'b0;
  logic [N-1:0] tile_ready = '0;
  logic [N-1:0] tile_reset;
  logic [N-1:0] tile_en;
  logic         seq_done;
  logic [N-1:0] timeout_flags;

  int n_checks = 0;
  int n_fail   = 0;
  int edge_n   = 0;

  // Scenario inputs: tile k's ready is driven high after edge rdy_at[k];
  // processors_en is driven high after edges in [pe_on, pe_off).
  int rdy_at[N];
  int pe_on;
  int pe_off;

  // Model results: release edge, advance edge, timeout flag per tile.
  int rel_edge[N];
  int adv_edge[N];
  bit to_flag[N];
  int done_edge;

  always #5 clk = ~clk;

  tile_start_sequencer #(
    .TILE_NUM(N), .RESET_HOLD(H), .STAGGER_CYCLES(S), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset), .processors_en(processors_en),
    .tile_ready(tile_ready), .tile_reset(tile_reset), .tile_en(tile_en),
    .seq_done(seq_done), .timeout_flags(timeout_flags)
  );

  function automatic bit pe_drive(int n);
    return (n >= pe_on) && (n < pe_off);
  endfunction

  // Tile k is released at e, may advance no earlier than e+S (stagger) and no earlier
  // than the first edge that samples ready high; the next release follows one edge later.
  function automatic void build_model();
    int e;
    int a;
    e = 2 + H;
    for (int k = 0; k < N; k++) begin
      rel_edge[k] = e;
      a = (e + S > rdy_at[k] + 1) ? e + S : rdy_at[k] + 1;
      to_flag[k] = 1'b0;
`ifdef SEQ_TIMEOUT_EN
      if (a > e + T) begin
        a = e + T;
        to_flag[k] = 1'b1;
      end
`endif
      adv_edge[k] = a;
      e = a + 1;
    end
    done_edge = adv_edge[N-1];
  endfunction

  task automatic check(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s at edge %0d: observed %h expected %h", tag, edge_n, got, exp);
    end
  endtask

  task automatic step();
    logic [N-1:0] exp_rst;
    logic [N-1:0] exp_to;
    logic [N-1:0] exp_en;
    logic         in_reset;
    in_reset = reset;
    @(posedge clk);
    #1;
    if (in_reset) begin
      edge_n = 0;
      check("reset_tile_reset", tile_reset, '1);
      check("reset_tile_en", tile_en, '0);
      check("reset_seq_done", N'(seq_done), '0);
      check("reset_timeout_flags", timeout_flags, '0);
    end else begin
      edge_n++;
      for (int k = 0; k < N; k++) begin
        exp_rst[k] = !(edge_n >= rel_edge[k]);
        exp_to[k]  = to_flag[k] && (edge_n >= adv_edge[k]);
      end
      exp_en = (edge_n >= done_edge + 1 && pe_drive(edge_n - 1)) ? '1 : '0;
      check("tile_reset", tile_reset, exp_rst);
      check("seq_done", N'(seq_done), N'(edge_n >= done_edge));
      check("tile_en", tile_en, exp_en);
      check("timeout_flags", timeout_flags, exp_to);
    end
    for (int k = 0; k < N; k++) tile_ready[k] = (edge_n >= rdy_at[k]);
    processors_en = pe_drive(edge_n);
  endtask

  task automatic run_edges(input int count);
    repeat (count) step();
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic set_scenario(input int stuck_tile, input int stuck_at, input int on, input int off);
    for (int k = 0; k < N; k++) rdy_at[k] = 0;
    if (stuck_tile >= 0) rdy_at[stuck_tile] = stuck_at;
    pe_on  = on;
    pe_off = off;
    build_model();
  endtask

  initial begin
    // Nominal: all ready, processors_en high throughout.
    set_scenario(-1, 0, 0, NEVER);
    apply_reset(3);
    run_edges(done_edge + 5);

    // Late ready on tile 5 (held low until edge 60).
    set_scenario(5, 60, 0, NEVER);
    apply_reset(1);
    run_edges(done_edge + 5);

    // Enable gating: processors_en rises after edge 100, falls after edge 120.
    set_scenario(-1, 0, 100, 120);
    apply_reset(1);
    run_edges(130);

    // Mid-sequence reset at edge 40, then a clean nominal restart.
    set_scenario(-1, 0, 0, NEVER);
    apply_reset(1);
    run_edges(39);
    apply_reset(1);
    run_edges(done_edge + 5);

    // Tile 3 never ready: stalls (or times out when the timeout is built in).
    set_scenario(3, NEVER, 0, NEVER);
    apply_reset(1);
    run_edges(2000);

    // Randomized ready arrival and enable window.
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < N; k++) rdy_at[k] = int'($urandom_range(0, 20 + 8 * k));
      pe_on  = int'($urandom_range(0, 150));
      pe_off = pe_on + int'($urandom_range(1, 80));
      build_model();
      apply_reset(int'($urandom_range(1, 3)));
      run_edges(done_edge + 40);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
